wtfpga_top: RTL and testbench

- Board-level top of the WTFpga workshop design for a 16 MHz ECP5 board.
- Reads 8 switches on pmod_a and mirrors them to the LED bar; drives RGB LEDs from logic gates of two switches.
- Drives a 2-digit multiplexed seven-segment display on pmod_b, showing either the switch byte in hex or a BCD stopwatch.
- Blinks a heartbeat LED.

---
 rtl/wtfpga_pkg.sv | 46 ++++
 rtl/wtfpga_top_hex_to_seg7.sv | 14 +
 rtl/wtfpga_top.sv | 125 ++++++++++++
 tb/tb_wtfpga_top.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/wtfpga_pkg.sv
// Shared types, divider helpers and the seven-segment table
// for the WTFpga workshop board top.
package wtfpga_pkg;

    typedef logic [3:0] bcd_t;

    localparam int DEF_CLK_HZ   = 16000000;
    localparam int DEF_MUX_TC   = DEF_CLK_HZ / 1000;
    localparam int DEF_TICK_TC  = DEF_CLK_HZ / 1000;
    localparam int DEF_BLINK_TC = DEF_CLK_HZ / (2 * 2);

    function automatic int div_tc(input int clk_hz, input int hz);
        int tc;
        tc = clk_hz / hz;
        return (tc < 1) ? 1 : tc;
    endfunction

    // A terminal count of 1 still needs a 1-bit counter.
    function automatic int cnt_w(input int tc);
        return (tc <= 1) ? 1 : $clog2(tc);
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/wtfpga_top_hex_to_seg7.sv
// Combinational nibble to seven-segment decoder,
// segments g..a with bit0 = a, active-high.
module hex_to_seg7
    import wtfpga_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = seg7(hex);
    end

endmodule

// File: rtl/wtfpga_top.sv
// WTFpga board top: switch mirror, RGB gates, heartbeat and
// a two-digit muxed display in hex or BCD stopwatch mode.
module wtfpga_top
    import wtfpga_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 16000000,
    parameter int MUX_HZ      = 1000,
    parameter int TICK_HZ     = 1000,
    parameter int BLINK_HZ    = 2
) (
    input  logic       clk_16mhz,
    input  logic       rst,
    input  logic [7:0] pmod_a,
    output logic [7:0] pmod_b,
    output logic [7:0] led,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b,
    output logic       led_usr,
    output logic       led_act
);

    localparam int MUX_TC   = div_tc(CLK_FREQ_HZ, MUX_HZ);
    localparam int TICK_TC  = div_tc(CLK_FREQ_HZ, TICK_HZ);
    localparam int BLINK_TC = div_tc(CLK_FREQ_HZ, 2 * BLINK_HZ);
    localparam int MUX_W    = cnt_w(MUX_TC);
    localparam int TICK_W   = cnt_w(TICK_TC);
    localparam int BLINK_W  = cnt_w(BLINK_TC);

    logic [7:0] sync_q;
    logic [7:0] sw;

    always_ff @(posedge clk_16mhz or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            sw     <= '0;
        end else begin
            sync_q <= pmod_a;
            sw     <= sync_q;
        end
    end

    logic [TICK_W-1:0]  tick_cnt;
    logic [MUX_W-1:0]   mux_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic               tick;
    logic               mux_hit;
    logic               blink_hit;
    logic               sel;

    assign tick      = (tick_cnt == TICK_W'(TICK_TC - 1));
    assign mux_hit   = (mux_cnt == MUX_W'(MUX_TC - 1));
    assign blink_hit = (blink_cnt == BLINK_W'(BLINK_TC - 1));

    always_ff @(posedge clk_16mhz or posedge rst) begin
        if (rst) begin
            tick_cnt  <= '0;
            mux_cnt   <= '0;
            blink_cnt <= '0;
            sel       <= 1'b0;
            led_usr   <= 1'b0;
        end else begin
            tick_cnt  <= tick ? '0 : tick_cnt + TICK_W'(1);
            mux_cnt   <= mux_hit ? '0 : mux_cnt + MUX_W'(1);
            blink_cnt <= blink_hit ? '0 : blink_cnt + BLINK_W'(1);
            if (mux_hit) sel <= ~sel;
            if (blink_hit) led_usr <= ~led_usr;
        end
    end

    bcd_t ones;
    bcd_t tens;

    // Clear wins over increment; count is frozen outside stopwatch mode.
    always_ff @(posedge clk_16mhz or posedge rst) begin
        if (rst) begin
            ones <= '0;
            tens <= '0;
        end else if (sw[4]) begin
            if (sw[6]) begin
                ones <= '0;
                tens <= '0;
            end else if (tick && !sw[5]) begin
                if (ones == 4'd9) begin
                    ones <= '0;
                    tens <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
                end else begin
                    ones <= ones + 4'd1;
                end
            end
        end
    end

    bcd_t       dig0;
    bcd_t       dig1;
    bcd_t       dig_sel;
    logic [6:0] seg;

    always_comb begin
        dig0 = sw[3:0];
        dig1 = sw[7:4];
        if (sw[4]) begin
            dig0 = ones;
            dig1 = tens;
        end
        dig_sel = sel ? dig1 : dig0;
    end

    hex_to_seg7 u_seg (
        .hex (dig_sel),
        .seg (seg)
    );

    always_ff @(posedge clk_16mhz or posedge rst) begin
        if (rst) pmod_b <= 8'h00;
        else     pmod_b <= {sel, seg};
    end

    assign led     = sw;
    assign led_r   = sw[0] & sw[1];
    assign led_g   = sw[0] | sw[1];
    assign led_b   = sw[0] ^ sw[1];
    assign led_act = sw[4];

endmodule

// File: tb/tb_wtfpga_top.sv
// Scoreboard bench for wtfpga_top with 16-cycle dividers.
// Expected display words come from a cycle model of mux/tick phase.
module tb_wtfpga_top;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pmod_a;
    logic [7:0] pmod_b;
    logic [7:0] led;
    logic       led_r;
    logic       led_g;
    logic       led_b;
    logic       led_usr;
    logic       led_act;

    wtfpga_top #(
        .CLK_FREQ_HZ (16000),
        .MUX_HZ      (1000),
        .TICK_HZ     (1000),
        .BLINK_HZ    (500)
    ) dut (
        .clk_16mhz (clk),
        .rst       (rst),
        .pmod_a    (pmod_a),
        .pmod_b    (pmod_b),
        .led       (led),
        .led_r     (led_r),
        .led_g     (led_g),
        .led_b     (led_b),
        .led_usr   (led_usr),
        .led_act   (led_act)
    );

    always #5 clk = ~clk;

    // Number of rising edges since reset release.
    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int         n_tests = 0;
    int         n_fail  = 0;
    int         k0      = 0;
    logic [7:0] exp_q[$];

    function automatic logic [6:0] seg_ref(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;
            2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;
            6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            10: return 7'h77; 11: return 7'h7C;
            12: return 7'h39; 13: return 7'h5E;
            14: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    // Word registered at edge m+1 from state after edge m.
    function automatic logic [7:0] disp_exp(input int m, input int d0,
                                            input int d1);
        logic s;
        s = ((m / 16) % 2) == 1;
        return {s, seg_ref(s ? d1 : d0)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, want);
        end
    endtask

    task automatic check_hex(input int n, input logic [7:0] v,
                             input string tag);
        logic [7:0] e;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(disp_exp(cyc, int'(v[3:0]), int'(v[7:4])));
            step();
            e = exp_q.pop_front();
            n_tests++;
            if (pmod_b !== e) begin
                n_fail++;
                $display("FAIL %s cyc=%0d pmod_b=%h want=%h",
                         tag, cyc, pmod_b, e);
            end
        end
    endtask

    task automatic check_count(input int n, input bit run, input int base,
                               input string tag);
        logic [7:0] e;
        int c;
        for (int i = 0; i < n; i++) begin
            c = run ? (base + (cyc - k0) / 16) % 100 : base;
            exp_q.push_back(disp_exp(cyc, c % 10, c / 10));
            step();
            e = exp_q.pop_front();
            n_tests++;
            if (pmod_b !== e) begin
                n_fail++;
                $display("FAIL %s cyc=%0d pmod_b=%h want=%h",
                         tag, cyc, pmod_b, e);
            end
        end
    endtask

    task automatic align_tick();
        for (int i = 0; i < 17; i++) begin
            if (cyc % 16 == 0) break;
            step();
        end
        n_tests++;
        if (cyc % 16 != 0) begin
            n_fail++;
            $display("FAIL align_tick cyc=%0d want multiple of 16", cyc);
        end
        k0 = cyc;
    endtask

    task automatic test_reset();
        pmod_a = 8'hFF;
        repeat (20) step();
        chk("pre_reset_led", led, 8'hFF);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_pmod_b", pmod_b, 8'h00);
        chk("rst_led", led, 8'h00);
        chk("rst_misc", {3'b000, led_r, led_g, led_b, led_usr, led_act},
            8'h00);
        pmod_a = 8'h00;
        repeat (3) step();
        chk("rst_hold_pmod_b", pmod_b, 8'h00);
        chk("rst_hold_usr", {7'd0, led_usr}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_heartbeat();
        for (int i = 0; i < 64; i++) begin
            step();
            chk("heartbeat", {7'd0, led_usr}, 8'((cyc / 16) % 2));
        end
    endtask

    task automatic test_hex_a5();
        pmod_a = 8'hA5;
        step();
        chk("a5_latency1", led, 8'h00);
        step();
        chk("a5_led", led, 8'hA5);
        chk("a5_rgb_act", {4'd0, led_r, led_g, led_b, led_act}, 8'h06);
        step();
        check_hex(48, 8'hA5, "a5_disp");
    endtask

    task automatic test_hex_03();
        pmod_a = 8'h03;
        repeat (3) step();
        chk("03_led", led, 8'h03);
        chk("03_rgb_act", {4'd0, led_r, led_g, led_b, led_act}, 8'h0C);
        check_hex(48, 8'h03, "03_disp");
    endtask

    task automatic test_stopwatch_ten();
        align_tick();
        pmod_a = 8'h10;
        repeat (3) step();
        chk("sw_act", {7'd0, led_act}, 8'h01);
        check_count(160 - 3, 1'b1, 0, "sw_run10");
        pmod_a = 8'h30;
        repeat (3) step();
        check_count(48, 1'b0, 10, "sw_pause10");
        chk("sw_pause_act", {7'd0, led_act}, 8'h01);
        pmod_a = 8'h50;
        repeat (4) step();
        check_count(40, 1'b0, 0, "sw_clear");
    endtask

    task automatic test_wrap();
        align_tick();
        pmod_a = 8'h10;
        repeat (3) step();
        check_count(104 * 16 - 3, 1'b1, 0, "sw_wrap");
    endtask

    task automatic test_hold();
        pmod_a = 8'h01;
        repeat (3) step();
        chk("hold_act", {7'd0, led_act}, 8'h00);
        check_hex(48, 8'h01, "hold_hex01");
        pmod_a = 8'h30;
        repeat (3) step();
        check_count(48, 1'b0, 4, "hold_resume");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        pmod_a = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_heartbeat();
        test_hex_a5();
        test_hex_03();
        test_stopwatch_ten();
        test_wrap();
        test_hold();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
